window_generator_3x3: RTL and testbench

WINDOW_GENERATOR_3X3 -- requirements
Module: window_generator_3x3

---
 rtl/window_generator_3x3.sv | 132 +++++++++++++
 tb/tb_window_generator_3x3.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_generator_3x3.sv
// 3x3 sliding-window generator for a raster-order pixel stream.
// Two line buffers supply the two rows above the incoming pixel. A 3x3 shift
// register gathers the current neighbourhood. Complete windows are held on
// win_0..win_8 under a valid/ready handshake toward the dot-product engine.
module window_generator_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] win_0,
    output logic [PIX_W-1:0] win_1,
    output logic [PIX_W-1:0] win_2,
    output logic [PIX_W-1:0] win_3,
    output logic [PIX_W-1:0] win_4,
    output logic [PIX_W-1:0] win_5,
    output logic [PIX_W-1:0] win_6,
    output logic [PIX_W-1:0] win_7,
    output logic [PIX_W-1:0] win_8,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef logic [PIX_W-1:0] pix_t;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // line_1 holds row-1, line_2 holds row-2, both indexed by column
    pix_t line_1 [IMG_W];
    pix_t line_2 [IMG_W];

    // Neighbourhood shift register: [row][col], row 0 = oldest row, col 2 = newest column
    pix_t sr      [3][3];
    pix_t sr_next [3][3];

    pix_t win_q [9];

    logic accept;
    logic last_col;
    logic last_row;
    logic win_hit;

    // The window register may take a new pixel whenever it is empty or being drained
    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign last_col  = (col == COL_W'(IMG_W - 1));
    assign last_row  = (row == ROW_W'(IMG_H - 1));

    // Only pixels with two rows above and two columns to the left close a window,
    // so windows never straddle a row or frame boundary
    assign win_hit   = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // Neighbourhood as it will look after the current pixel is shifted in
    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch is inferred.
        for (int r = 0; r < 3; r++) begin
            sr_next[r][0] = sr[r][1];
            sr_next[r][1] = sr[r][2];
        end
        sr_next[0][2] = line_2[col];
        sr_next[1][2] = line_1[col];
        sr_next[2][2] = pix_in;
    end

    // Line buffers and shift register advance once per accepted pixel
    always_ff @(posedge clk) begin
        // NOTE: storage arrays carry no reset; the row/col gating keeps stale
        // contents out of every valid window.
        if (accept) begin
            line_2[col] <= line_1[col];
            line_1[col] <= pix_in;
            sr          <= sr_next;
        end
    end

    // Raster position, window output register and frame-end pulse
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values.
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            frame_done <= accept && last_col && last_row;

            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (accept && win_hit) begin
                win_valid <= 1'b1;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win_q[r*3 + c] <= sr_next[r][c];
                    end
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    assign win_0 = win_q[0];
    assign win_1 = win_q[1];
    assign win_2 = win_q[2];
    assign win_3 = win_q[3];
    assign win_4 = win_q[4];
    assign win_5 = win_q[5];
    assign win_6 = win_q[6];
    assign win_7 = win_q[7];
    assign win_8 = win_q[8];

endmodule

// File: tb/tb_window_generator_3x3.sv
// Self-checking bench for window_generator_3x3.
// Instance a is 4x4 and is checked against an image-array reference model.
// Instance b is 5x3 and runs a short directed stream.
module tb_window_generator_3x3;

    localparam int A_W = 4;
    localparam int A_H = 4;

    typedef logic [8:0][7:0] win_t;

    typedef struct {
        logic       pv;
        logic [7:0] px;
        logic       exp_valid;
        win_t       exp_win;
        logic       exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic [7:0] a_pix;
    logic       a_pv, a_ready, a_wr, a_wv, a_fd;
    logic [7:0] a_w [9];

    logic [7:0] b_pix;
    logic       b_pv, b_ready, b_wr, b_wv, b_fd;
    logic [7:0] b_w [9];

    always #5 clk = ~clk;

    window_generator_3x3 #(.IMG_W(A_W), .IMG_H(A_H), .PIX_W(8)) dut_a (
        .clk(clk), .rst(rst), .pix_in(a_pix), .pix_valid(a_pv), .pix_ready(a_ready),
        .win_0(a_w[0]), .win_1(a_w[1]), .win_2(a_w[2]), .win_3(a_w[3]), .win_4(a_w[4]),
        .win_5(a_w[5]), .win_6(a_w[6]), .win_7(a_w[7]), .win_8(a_w[8]),
        .win_valid(a_wv), .win_ready(a_wr), .frame_done(a_fd)
    );

    window_generator_3x3 #(.IMG_W(5), .IMG_H(3), .PIX_W(8)) dut_b (
        .clk(clk), .rst(rst), .pix_in(b_pix), .pix_valid(b_pv), .pix_ready(b_ready),
        .win_0(b_w[0]), .win_1(b_w[1]), .win_2(b_w[2]), .win_3(b_w[3]), .win_4(b_w[4]),
        .win_5(b_w[5]), .win_6(b_w[6]), .win_7(b_w[7]), .win_8(b_w[8]),
        .win_valid(b_wv), .win_ready(b_wr), .frame_done(b_fd)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: current frame image, pending windows, consumed windows
    logic [7:0] img [A_H][A_W];
    win_t       mq[$];
    win_t       got_q[$];
    int         mk     = 0;
    bit         exp_fd = 1'b0;

    // Observations of the most recent cycle_a call
    logic obs_valid, obs_done;
    win_t obs_win;

    vec_t tbl [17];

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_win(input string name, input win_t got, input win_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Window whose top-left pixel value is top, in an image of width w where pixel = top-left + r*w + c
    function automatic win_t win_at(input int top, input int w);
        win_t x;
        for (int i = 0; i < 9; i++) x[i] = 8'(top + (i / 3) * w + (i % 3));
        return x;
    endfunction

    function automatic win_t pack_a();
        win_t x;
        for (int i = 0; i < 9; i++) x[i] = a_w[i];
        return x;
    endfunction

    function automatic win_t pack_b();
        win_t x;
        for (int i = 0; i < 9; i++) x[i] = b_w[i];
        return x;
    endfunction

    // One clock cycle on instance a: drive at the falling edge, sample 1 time unit later,
    // compare against the model, advance the model, then wait for the next falling edge.
    task automatic cycle_a(input logic pv, input logic [7:0] px, input logic wr, output logic acc);
        logic exp_valid;
        win_t w;
        int   r, c;
        a_pv = pv; a_pix = px; a_wr = wr;
        #1;
        obs_valid = a_wv;
        obs_done  = a_fd;
        obs_win   = pack_a();
        exp_valid = (mq.size() != 0);
        check_bit("a_win_valid", a_wv, exp_valid);
        check_bit("a_pix_ready", a_ready, !exp_valid || wr);
        check_bit("a_frame_done", a_fd, exp_fd);
        if (exp_valid) begin
            check_win("a_window", obs_win, mq[0]);
            if (wr) got_q.push_back(mq.pop_front());
        end
        acc    = pv && (!exp_valid || wr);
        exp_fd = 1'b0;
        if (acc) begin
            r = mk / A_W;
            c = mk % A_W;
            img[r][c] = px;
            if (r >= 2 && c >= 2) begin
                for (int i = 0; i < 9; i++) w[i] = img[r - 2 + i / 3][c - 2 + i % 3];
                mq.push_back(w);
            end
            mk++;
            if (mk == A_W * A_H) begin
                mk     = 0;
                exp_fd = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: continuous; 1: win_ready low for 5 cycles after the first window;
    // 2: pix_valid 1,0,0 pattern; 3: random valid/ready and random pixels
    task automatic run_stream(input int n, input int base, input int mode);
        int         k    = 0;
        int         cyc  = 0;
        int         hold = 0;
        bit         seen = 1'b0;
        logic       pv, wr, acc;
        logic [7:0] px;
        while (k < n && cyc < 2000) begin
            pv = 1'b1;
            wr = 1'b1;
            case (mode)
                1: begin
                    if (!seen && mq.size() != 0) begin
                        seen = 1'b1;
                        hold = 5;
                    end
                    if (hold > 0) begin
                        wr = 1'b0;
                        hold--;
                    end
                end
                2: pv = (cyc % 3 == 0);
                3: begin
                    pv = 1'($urandom_range(0, 1));
                    wr = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            px = (mode == 3) ? 8'($urandom) : 8'(base + k);
            cycle_a(pv, px, wr, acc);
            if (acc) k++;
            cyc++;
        end
        check_int("stream_accepted", k, n);
    endtask

    task automatic drain_a(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle_a(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        a_pv = 1'b0; a_wr = 1'b0;
        b_pv = 1'b0; b_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mk     = 0;
        exp_fd = 1'b0;
        #1;
        check_bit("rst_a_valid", a_wv, 1'b0);
        check_bit("rst_a_done", a_fd, 1'b0);
        check_bit("rst_a_ready", a_ready, 1'b1);
        check_win("rst_a_window", pack_a(), '0);
        check_bit("rst_b_valid", b_wv, 1'b0);
        check_bit("rst_b_ready", b_ready, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   nb, nfd;

        rst = 1'b1;
        a_pix = '0; a_pv = 1'b0; a_wr = 1'b0;
        b_pix = '0; b_pv = 1'b0; b_wr = 1'b0;
        repeat (2) @(negedge clk);
        reset_all();

        // Continuous 4x4 frame, cycle-exact expectations
        for (int i = 0; i < 17; i++) begin
            tbl[i].pv        = (i < 16);
            tbl[i].px        = 8'(i);
            tbl[i].exp_valid = 1'b0;
            tbl[i].exp_win   = '0;
            tbl[i].exp_done  = 1'b0;
        end
        tbl[11].exp_valid = 1'b1;
        tbl[11].exp_win   = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        tbl[12].exp_valid = 1'b1;
        tbl[12].exp_win   = win_at(1, A_W);
        tbl[15].exp_valid = 1'b1;
        tbl[15].exp_win   = win_at(4, A_W);
        tbl[16].exp_valid = 1'b1;
        tbl[16].exp_win   = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
        tbl[16].exp_done  = 1'b1;
        got_q.delete();
        for (int i = 0; i < 17; i++) begin
            cycle_a(tbl[i].pv, tbl[i].px, 1'b1, acc);
            check_bit("tbl_valid", obs_valid, tbl[i].exp_valid);
            check_bit("tbl_done", obs_done, tbl[i].exp_done);
            if (tbl[i].exp_valid) check_win("tbl_window", obs_win, tbl[i].exp_win);
        end
        drain_a(2);
        check_int("tbl_window_count", got_q.size(), 4);

        // Back-pressure: window held while win_ready is low
        got_q.delete();
        run_stream(16, 0, 1);
        drain_a(3);
        check_int("bp_window_count", got_q.size(), 4);
        check_win("bp_first", got_q[0], win_at(0, A_W));
        check_win("bp_second", got_q[1], win_at(1, A_W));

        // Gapped input: pix_valid 1,0,0,...
        got_q.delete();
        run_stream(16, 0, 2);
        drain_a(3);
        check_int("gap_window_count", got_q.size(), 4);
        check_win("gap_first", got_q[0], win_at(0, A_W));
        check_win("gap_last", got_q[3], win_at(5, A_W));

        // Two frames back to back
        got_q.delete();
        run_stream(16, 0, 0);
        run_stream(16, 100, 0);
        drain_a(3);
        check_int("b2b_window_count", got_q.size(), 8);
        check_win("b2b_f1_last", got_q[3], win_at(5, A_W));
        check_win("b2b_f2_first", got_q[4], win_at(100, A_W));

        // Reset mid-frame after pixel 9, then restart
        run_stream(10, 0, 0);
        reset_all();
        got_q.delete();
        run_stream(16, 0, 0);
        drain_a(3);
        check_int("rst_mid_window_count", got_q.size(), 4);
        check_win("rst_mid_first", got_q[0], win_at(0, A_W));
        check_win("rst_mid_last", got_q[3], win_at(5, A_W));

        // 5x3 image on instance b
        nb  = 0;
        nfd = 0;
        for (int i = 0; i < 20; i++) begin
            b_pv = (i < 15); b_pix = 8'(i); b_wr = 1'b1;
            #1;
            if (i == 0) check_bit("b_ready", b_ready, 1'b1);
            if (b_wv) begin
                nb++;
                if (nb == 1) check_win("b_first", pack_b(), win_at(0, 5));
                if (nb == 3) check_win("b_last", pack_b(), win_at(2, 5));
            end
            if (b_fd) begin
                nfd++;
                check_bit("b_done_with_valid", b_wv, 1'b1);
                check_int("b_done_at_window", nb, 3);
            end
            @(negedge clk);
        end
        b_pv = 1'b0;
        check_int("b_window_count", nb, 3);
        check_int("b_frame_done_count", nfd, 1);

        // Random valid/ready and pixel values across four frames
        got_q.delete();
        run_stream(64, 0, 3);
        drain_a(4);
        check_int("rand_window_count", got_q.size(), 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
